mips_mc_control: RTL and testbench
==================================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter: ALUCTRL_W, default 3, width of alu_control output.
REQ-002 clock  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction[31:26] from instruction register.
REQ-005 funct  input  6  instruction[5:0] from instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pc_en  output  1  PC load enable = pc_write OR (pc_write_cond AND zero).
REQ-008 i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath strobes/selects.
REQ-009 alu_src_b, pc_source  output  2 each  mux selects.
REQ-010 alu_control  output  ALUCTRL_W  ALU operation code.
REQ-011 state_o  output  4  current state encoding, for debug.
REQ-012 illegal_op  output  1  one-cycle pulse in DECODE on unsupported opcode.

Function
REQ-013 Moore FSM; all outputs except pc_en and alu_control are decoded from state only.
REQ-014 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-015 FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00; next DECODE.
REQ-016 DECODE: alu_src_b=11, alu_op=00; next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX, other -> FETCH with illegal_op=1.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10; lw -> MEMRD, sw -> MEMWR.
REQ-018 MEMRD: mem_read=1, i_or_d=1 -> MEMWB; MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
REQ-019 MEMWR: mem_write=1, i_or_d=1 -> FETCH.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB; ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
REQ-022 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB; ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-024 Latency in cycles incl. FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-025 alu_control combinational from alu_op/funct: 00 -> 010, 01 -> 110; 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other funct -> 010.
REQ-026 Unasserted strobes are 0; unasserted selects are 00/0; no output is X in any state.
REQ-027 Unused encodings 12-15 shall return to FETCH next cycle with all strobes 0.

Reset
REQ-028 reset asserted: state -> FETCH immediately (asynchronous), independent of clock.
REQ-029 While reset high, pc_en, pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op forced 0; selects show FETCH values; state_o=0.
REQ-030 Reset mid-instruction abandons it; first rising edge after deassertion executes FETCH.

Configuration
REQ-031 Macro MIPS_CTRL_ADDI_EN: defined -> ADDIEX/ADDIWB present, opcode 001000 supported; undefined -> states absent, 001000 treated as illegal (DECODE -> FETCH, illegal_op=1).

Structure
REQ-032 Package mips_ctrl_pkg holds opcode constants, funct constants, state encoding typedef, ALU-op and alu_control constants.
REQ-033 One sub-module mips_alu_decoder implements REQ-025.

Verification
REQ-034 Reset pulse mid-MEMRD -> state_o=0 immediately, all write strobes 0; next edge after release in DECODE.
REQ-035 opcode=100011 -> state_o sequence 0,1,2,3,4,0; reg_write=1 only in state 4.
REQ-036 opcode=000100, zero=1 -> pc_en=1 in BRANCH; zero=0 -> pc_en=0; 3 cycles each.
REQ-037 opcode=000000, funct=101010 -> alu_control=111 in EXEC; sequence 0,1,6,7,0.
REQ-038 opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH.
REQ-039 opcode=001000 with MIPS_CTRL_ADDI_EN -> 0,1,9,10,0; without -> illegal_op=1, 0,1,0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and decode helpers for the multicycle MIPS control unit.
// Build option MIPS_CTRL_ADDI_EN adds the ADDIEX/ADDIWB states and accepts opcode 001000.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
`ifdef MIPS_CTRL_ADDI_EN
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
`endif
    S_JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
         (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_CTRL_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op);
    state_t nxt;
    nxt = S_FETCH;
    case (s)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      nxt = S_ADDIEX;
`endif
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = S_MEMWB;
      S_EXEC:   nxt = S_ALUWB;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: nxt = S_ADDIWB;
`endif
      // Write-back, branch, jump and the unused encodings all end the instruction.
      default:  nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_BOFS;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_OUT;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
`endif
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU operation decoder: maps the control unit's ALU op and the R-type funct field
// to the ALU control code.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           i_alu_op,
  input  logic [5:0]           i_funct,
  output logic [ALUCTRL_W-1:0] o_alu_control
);

  logic [2:0] w_ctl;

  always_comb begin
    w_ctl = ALUCTL_ADD;
    case (i_alu_op)
      ALUOP_SUB: w_ctl = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  w_ctl = ALUCTL_ADD;
          FN_SUB:  w_ctl = ALUCTL_SUB;
          FN_AND:  w_ctl = ALUCTL_AND;
          FN_OR:   w_ctl = ALUCTL_OR;
          FN_SLT:  w_ctl = ALUCTL_SLT;
          default: w_ctl = ALUCTL_ADD;
        endcase
      end
      default: w_ctl = ALUCTL_ADD;
    endcase
  end

  assign o_alu_control = ALUCTRL_W'(w_ctl);

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit (Moore FSM); MIPS_CTRL_ADDI_EN enables addi support.
// Strobe/select outputs are registered from the next state; reset masks the strobes.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 pc_en,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_source,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [3:0]           state_o,
  output logic                 illegal_op
);

  state_t r_state;
  ctrl_t  r_ctrl;
  state_t w_state_nxt;
  logic   w_run;

  assign w_state_nxt = next_state(r_state, opcode);

  // Outputs are loaded together with the state so they are glitch-free registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= ctrl_decode(S_FETCH);
    end else begin
      r_state <= w_state_nxt;
      r_ctrl  <= ctrl_decode(w_state_nxt);
    end
  end

  assign w_run = ~reset;

  assign i_or_d     = r_ctrl.i_or_d;
  assign mem_read   = r_ctrl.mem_read  & w_run;
  assign mem_write  = r_ctrl.mem_write & w_run;
  assign ir_write   = r_ctrl.ir_write  & w_run;
  assign reg_write  = r_ctrl.reg_write & w_run;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign reg_dst    = r_ctrl.reg_dst;
  assign alu_src_a  = r_ctrl.alu_src_a;
  assign alu_src_b  = r_ctrl.alu_src_b;
  assign pc_source  = r_ctrl.pc_source;
  assign state_o    = r_state;

  assign pc_en = w_run & (r_ctrl.pc_write | (r_ctrl.pc_write_cond & zero));

  assign illegal_op = w_run & (r_state == S_DECODE) & ~op_supported(opcode);

  mips_alu_decoder #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_dec (
    .i_alu_op      (r_ctrl.alu_op),
    .i_funct       (funct),
    .o_alu_control (alu_control)
  );

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed plus randomized instruction stream checked against a per-instruction
// state-sequence and per-state output model of the multicycle control unit.
module tb_mips_mc_control;

`ifdef MIPS_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_control;
  logic [3:0] state_o;
  logic       illegal_op;

  int errors = 0;
  int checks = 0;

  mips_mc_control #(.ALUCTRL_W(3)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_control(alu_control), .state_o(state_o), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  function automatic bit legal(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b000010) || (ADDI_EN && op == 6'b001000);
  endfunction

  // Expected order of states visited by one instruction, starting at FETCH.
  function automatic void build_seq(input logic [5:0] op, output int seq[$]);
    seq = {0, 1};
    case (op)
      6'b100011: seq = {seq, 2, 3, 4};
      6'b101011: seq = {seq, 2, 5};
      6'b000000: seq = {seq, 6, 7};
      6'b000100: seq = {seq, 8};
      6'b000010: seq = {seq, 11};
      6'b001000: if (ADDI_EN) seq = {seq, 9, 10};
      default: ;
    endcase
  endfunction

  // Packed as {pc_en,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b,pc_source,illegal_op}
  function automatic logic [13:0] exp_out(input int s, input logic [5:0] op, input logic z, input bit rst);
    logic pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, ps;
    {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00;
    case (s)
      0:  begin mr = 1; irw = 1; sb = 2'b01; pcw = 1; end
      1:  begin sb = 2'b11; ill = !legal(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  sa = 1;
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; pcc = 1; ps = 2'b01; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    if (rst) begin
      {pcw, pcc, mr, mw, irw, rw, ill} = '0;
    end
    return {pcw | (pcc & z), iod, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ill};
  endfunction

  function automatic logic [2:0] exp_alu(input int s, input logic [5:0] fn);
    if (s == 8) return 3'b110;
    if (s != 6) return 3'b010;
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int s, input bit rst);
    logic [13:0] act;
    act = {pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, pc_source, illegal_op};
    check({tag, "_state"}, 32'(state_o), 32'(s));
    check({tag, "_outs"}, 32'(act), 32'(exp_out(s, opcode, zero, rst)));
    check({tag, "_aluctl"}, 32'(alu_control), 32'(exp_alu(s, funct)));
  endtask

  // Called while in FETCH; leaves the bench #1 after the edge that returns to FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
    int seq[$];
    opcode = op; funct = fn; zero = z;
    build_seq(op, seq);
    foreach (seq[i]) begin
      if (i > 0) begin
        @(posedge clock); #1;
      end
      check_cycle(tag, seq[i], 1'b0);
    end
    @(posedge clock); #1;
    check({tag, "_ret"}, 32'(state_o), 32'd0);
  endtask

  initial begin
    int kind;
    logic [5:0] op, fn;
    logic [5:0] fnlist [5];
    int tail [4];
    fnlist = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    tail = '{2, 3, 4, 0};

    reset = 1'b1; opcode = 6'b100011; funct = 6'b0; zero = 1'b1;
    #1;
    check_cycle("rst0", 0, 1'b1);
    @(posedge clock); #1;
    check_cycle("rst_hold", 0, 1'b1);
    @(negedge clock); reset = 1'b0; #1;
    check_cycle("rst_rel", 0, 1'b0);

    run_instr("lw", 6'b100011, 6'b000000, 1'b0);
    run_instr("beq_z1", 6'b000100, 6'b000000, 1'b1);
    run_instr("beq_z0", 6'b000100, 6'b000000, 1'b0);
    run_instr("rslt", 6'b000000, 6'b101010, 1'b0);
    run_instr("rsub", 6'b000000, 6'b100010, 1'b1);
    run_instr("illegal", 6'b111111, 6'b000000, 1'b0);
    run_instr("addi", 6'b001000, 6'b000000, 1'b0);
    run_instr("sw", 6'b101011, 6'b100100, 1'b1);
    run_instr("j", 6'b000010, 6'b000000, 1'b1);

    // Reset in the middle of a load's MEMRD cycle.
    opcode = 6'b100011; funct = 6'b0; zero = 1'b1;
    check_cycle("mr_f", 0, 1'b0);
    repeat (3) begin @(posedge clock); #1; end
    check_cycle("mr_rd", 3, 1'b0);
    #2 reset = 1'b1; #1;
    check_cycle("mr_async", 0, 1'b1);
    @(posedge clock); #1;
    check_cycle("mr_hold", 0, 1'b1);
    @(negedge clock); reset = 1'b0; #1;
    check_cycle("mr_rel", 0, 1'b0);
    @(posedge clock); #1;
    check_cycle("mr_dec", 1, 1'b0);
    foreach (tail[i]) begin
      @(posedge clock); #1;
      check_cycle("mr_tail", tail[i], 1'b0);
    end

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 6);
      fn = 6'($urandom_range(0, 63));
      case (kind)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin op = 6'b000000; if ($urandom_range(0, 1) == 1) fn = fnlist[$urandom_range(0, 4)]; end
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr("rnd", op, fn, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
